// File: rtl/rv32_prefetch_buffer.sv
// Purpose  : RV32 instruction prefetch buffer; req/gnt/rvalid fetch port feeding a valid/ready decode port.
// Latency  : rvalid to out_valid_o one cycle (zero with RV32_PREFETCH_BYPASS_EN when the FIFO is empty).
// Backpres.: requests issue only while a FIFO slot is reserved for every outstanding response.
// Ports    : clk_i, rst_i (sync, active-high); branch_i/branch_target_i redirect;
//            instr_req_o/instr_addr_o/instr_gnt_i/instr_rvalid_i/instr_rdata_i memory side;
//            out_valid_o/out_ready_i/out_instr_o/out_pc_o decode side.
// Option   : `define RV32_PREFETCH_BYPASS_EN to forward a response straight to out_* when the FIFO is empty.
module rv32_prefetch_buffer #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_ADDR      = 32'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_instr_o,
   output logic [31:0] out_pc_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = CW + 1;

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_e;

   state_e        state_q;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   pc_mem_q    [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] disc_q, disc_d;

   logic          credit_ok, gnt_fire, rv_fire, rv_keep, fifo_empty, push, pop;
   logic [31:0]   tgt_aligned;
   logic          unused_tgt_bits;

   assign tgt_aligned     = {branch_target_i[31:2], 2'b00};
   assign unused_tgt_bits = ^branch_target_i[1:0];

   // Outstanding requests count against FIFO space so every response has a slot waiting.
   // This also keeps a raised request stable until granted: only a grant can shrink the credit.
   assign credit_ok   = (outst_q < CW'(MAX_OUTSTANDING)) &&
                        (({1'b0, count_q} + {1'b0, outst_q}) < SW'(DEPTH));
   assign instr_req_o = (state_q != S_BOOT) && credit_ok;
   assign instr_addr_o = fetch_pc_q;

   assign gnt_fire   = instr_req_o & instr_gnt_i;
   // A response with nothing outstanding is a protocol error and is ignored entirely.
   assign rv_fire    = instr_rvalid_i & (outst_q != '0);
   // Responses to pre-redirect requests, or arriving with a redirect, are dropped.
   assign rv_keep    = rv_fire & (disc_q == '0) & ~branch_i;
   assign fifo_empty = (count_q == '0);
   assign pop        = ~fifo_empty & out_ready_i & ~branch_i;

`ifdef RV32_PREFETCH_BYPASS_EN
   logic bypass;
   assign bypass      = fifo_empty & rv_keep;
   assign out_valid_o = ~fifo_empty | bypass;
   assign out_instr_o = bypass ? instr_rdata_i : (fifo_empty ? 32'h0 : instr_mem_q[rd_ptr_q]);
   assign out_pc_o    = bypass ? rsp_pc_q      : (fifo_empty ? 32'h0 : pc_mem_q[rd_ptr_q]);
   // A forwarded response taken by decode this cycle never enters the FIFO.
   assign push        = rv_keep & ~(bypass & out_ready_i);
`else
   assign out_valid_o = ~fifo_empty;
   assign out_instr_o = fifo_empty ? 32'h0 : instr_mem_q[rd_ptr_q];
   assign out_pc_o    = fifo_empty ? 32'h0 : pc_mem_q[rd_ptr_q];
   assign push        = rv_keep;
`endif

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      outst_d    = outst_q + CW'(gnt_fire) - CW'(rv_fire);
      disc_d     = disc_q;
      if (branch_i) begin
         fetch_pc_d = tgt_aligned;
         rsp_pc_d   = tgt_aligned;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         // Everything still in flight after this cycle's handshakes belongs to the old stream.
         disc_d     = outst_d;
      end else begin
         if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (rv_keep)  rsp_pc_d   = rsp_pc_q + 32'd4;
         if (push)     wr_ptr_d   = wr_ptr_q + AW'(1);
         if (pop)      rd_ptr_d   = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
         if (rv_fire && (disc_q != '0)) disc_d = disc_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_BOOT;
         fetch_pc_q <= RESET_ADDR;
         rsp_pc_q   <= RESET_ADDR;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         outst_q    <= '0;
         disc_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         disc_q     <= disc_d;
         case (state_q)
            S_BOOT:  state_q <= S_RUN;
            S_RUN:   if (branch_i && (outst_d != '0)) state_q <= S_FLUSH;
            S_FLUSH: begin
               if (branch_i)              state_q <= (outst_d != '0) ? S_FLUSH : S_RUN;
               else if (disc_d == '0)     state_q <= S_RUN;
            end
            default: state_q <= S_BOOT;
         endcase
      end
   end

   // Storage needs no reset: out_* are masked while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (!rst_i && push) begin
         instr_mem_q[wr_ptr_q] <= instr_rdata_i;
         pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
      end
   end

endmodule

// File: tb/tb_rv32_prefetch_buffer.sv
// Purpose  : self-checking bench for rv32_prefetch_buffer with a memory model and output scoreboard.
// Latency  : memory answers each grant after a programmable number of cycles, in order.
// Backpres.: decode ready, grant and response availability are driven per scenario or randomly.
module tb_rv32_prefetch_buffer;

   localparam logic [31:0] RESET_ADDR = 32'h0;
`ifdef RV32_PREFETCH_BYPASS_EN
   localparam int EXP_LAT = 0;
`else
   localparam int EXP_LAT = 1;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        branch_i = 1'b0;
   logic [31:0] branch_target_i = 32'h0;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i = 1'b0;
   logic        instr_rvalid_i = 1'b0;
   logic [31:0] instr_rdata_i = 32'h0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] out_instr_o;
   logic [31:0] out_pc_o;

   always #5 clk_i = ~clk_i;

   rv32_prefetch_buffer dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .branch_i(branch_i), .branch_target_i(branch_target_i),
      .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
      .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_instr_o(out_instr_o), .out_pc_o(out_pc_o)
   );

   typedef struct { logic [31:0] addr; bit live; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   mreq_t       mem_q[$];
   exp_t        sb[$];
   int          n_chk = 0, n_fail = 0, cyc = 0, pops = 0, lat = 1;
   int          first_rv = -1, first_ov = -1;
   logic [31:0] first_instr = 32'h0;
   bit          rst = 1'b1, br = 1'b0, rdy = 1'b0, gnt_en = 1'b0, resp_en = 1'b1;
   bit          s_rv, s_ov;
   logic [31:0] br_tgt = 32'h0, exp_fetch = RESET_ADDR, last_pc = 32'h0;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return a ^ 32'h0000_0013;
   endfunction

   task automatic clear_model();
      mem_q.delete(); sb.delete();
      exp_fetch = RESET_ADDR; first_rv = -1; first_ov = -1; pops = 0;
   endtask

   // One clock: drive at the falling edge, sample 1ns later, update the models.
   task automatic step();
      mreq_t e;
      exp_t  x;
      @(negedge clk_i);
      cyc++;
      rst_i = rst; branch_i = br; branch_target_i = br_tgt;
      out_ready_i = rdy; instr_gnt_i = gnt_en;
      instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
      if (!rst && resp_en && mem_q.size() > 0) begin
         if (mem_q[0].due <= cyc) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = data_of(mem_q[0].addr);
         end
      end
      #1;
      s_rv = instr_rvalid_i; s_ov = out_valid_o;
      if (!rst) begin
         if (instr_rvalid_i) begin
            e = mem_q.pop_front();
            if (e.live && !branch_i) sb.push_back('{pc: e.addr, instr: data_of(e.addr)});
            if (first_rv < 0) first_rv = cyc;
         end
         if (out_valid_o && first_ov < 0) begin first_ov = cyc; first_instr = out_instr_o; end
         if (out_valid_o && out_ready_i && !branch_i) begin
            n_chk++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL pop_unexpected: got pc=%h instr=%h, required no output", out_pc_o, out_instr_o);
            end else begin
               x = sb.pop_front();
               if (out_pc_o !== x.pc || out_instr_o !== x.instr) begin
                  n_fail++;
                  $display("FAIL pop_data: got pc=%h instr=%h, required pc=%h instr=%h",
                           out_pc_o, out_instr_o, x.pc, x.instr);
               end
            end
            pops++; last_pc = out_pc_o;
         end
         if (branch_i) begin
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            sb.delete();
         end
         if (instr_req_o && instr_gnt_i) begin
            n_chk++;
            if (instr_addr_o !== exp_fetch) begin
               n_fail++;
               $display("FAIL grant_addr: got %h, required %h", instr_addr_o, exp_fetch);
            end
            mem_q.push_back('{addr: exp_fetch, live: !branch_i, due: cyc + lat});
         end
         if (branch_i) exp_fetch = {br_tgt[31:2], 2'b00};
         else if (instr_req_o && instr_gnt_i) exp_fetch = exp_fetch + 32'd4;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; br = 1'b0;
      step(); step();
      clear_model();
      rst = 1'b0;
      step();
   endtask

   task automatic branch_to(input logic [31:0] t);
      br_tgt = t; br = 1'b1; step(); br = 1'b0;
   endtask

   task automatic wait_pop(input string name, input logic [31:0] exp_pc);
      int p0 = pops;
      for (int i = 0; i < 40 && pops == p0; i++) step();
      n_chk++;
      if (pops == p0 || last_pc !== exp_pc) begin
         n_fail++;
         $display("FAIL %s: first pc got %h (pops %0d), required %h", name, last_pc, pops - p0, exp_pc);
      end
   endtask

   task automatic drain();
      gnt_en = 1'b0; resp_en = 1'b1; rdy = 1'b1;
      for (int i = 0; i < 60 && (mem_q.size() != 0 || sb.size() != 0 || out_valid_o); i++) step();
      n_chk++;
      if (mem_q.size() != 0 || sb.size() != 0 || out_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL drain: pending %0d expected %0d out_valid %b, required 0 0 0",
                  mem_q.size(), sb.size(), out_valid_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; gnt_en = 1'b1; rdy = 1'b1; lat = 1; resp_en = 1'b1;
      step(); step();
      n_chk++;
      if (instr_req_o !== 1'b0 || instr_addr_o !== RESET_ADDR || out_valid_o !== 1'b0 ||
          out_instr_o !== 32'h0 || out_pc_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got req=%b addr=%h vld=%b instr=%h pc=%h, required 0 %h 0 0 0",
                  instr_req_o, instr_addr_o, out_valid_o, out_instr_o, out_pc_o, RESET_ADDR);
      end
      clear_model();
      rst = 1'b0;
      step();
      n_chk++;
      if (instr_req_o !== 1'b0) begin
         n_fail++; $display("FAIL boot_req: got %b, required 0", instr_req_o);
      end
      step();
      n_chk++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== RESET_ADDR) begin
         n_fail++; $display("FAIL first_req: got req=%b addr=%h, required 1 %h", instr_req_o, instr_addr_o, RESET_ADDR);
      end
      drain();
   endtask

   task automatic test_stream();
      int p0;
      do_reset();
      rdy = 1'b1; gnt_en = 1'b1; resp_en = 1'b1; lat = 1;
      for (int i = 0; i < 10; i++) step();
      p0 = pops;
      for (int i = 0; i < 20; i++) step();
      n_chk++;
      if (pops - p0 != 20) begin
         n_fail++; $display("FAIL stream_rate: got %0d outputs in 20 cycles, required 20", pops - p0);
      end
      drain();
   endtask

   task automatic test_backpressure();
      do_reset();
      rdy = 1'b0; gnt_en = 1'b1; resp_en = 1'b1; lat = 1;
      for (int i = 0; i < 20; i++) step();
      n_chk++;
      if (instr_req_o !== 1'b0 || mem_q.size() + sb.size() != 4) begin
         n_fail++;
         $display("FAIL stall_credit: got req=%b inflight+stored=%0d, required 0 4", instr_req_o, mem_q.size() + sb.size());
      end
      n_chk++;
      if (out_valid_o !== 1'b1 || out_pc_o !== 32'h0 || out_instr_o !== 32'h13) begin
         n_fail++;
         $display("FAIL stall_head: got vld=%b pc=%h instr=%h, required 1 0 00000013", out_valid_o, out_pc_o, out_instr_o);
      end
      drain();
   endtask

   task automatic test_branch_discard();
      gnt_en = 1'b0; resp_en = 1'b0; rdy = 1'b1; lat = 1;
      branch_to(32'h10);
      gnt_en = 1'b1;
      for (int i = 0; i < 4; i++) step();
      n_chk++;
      if (instr_req_o !== 1'b0 || mem_q.size() != 2) begin
         n_fail++; $display("FAIL max_outstanding: got req=%b inflight=%0d, required 0 2", instr_req_o, mem_q.size());
      end
      branch_to(32'h103);
      resp_en = 1'b1;
      wait_pop("discard_then_target", 32'h100);
      drain();
   endtask

   task automatic test_retarget();
      gnt_en = 1'b0; resp_en = 1'b1; rdy = 1'b1; lat = 1;
      step();
      n_chk++;
      if (instr_req_o !== 1'b1) begin
         n_fail++; $display("FAIL retarget_pre: got req=%b, required 1", instr_req_o);
      end
      branch_to(32'h200);
      step();
      n_chk++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin
         n_fail++; $display("FAIL retarget_addr: got req=%b addr=%h, required 1 00000200", instr_req_o, instr_addr_o);
      end
      gnt_en = 1'b1;
      wait_pop("retarget_first", 32'h200);
      drain();
   endtask

   task automatic test_branch_rvalid_pop();
      rdy = 1'b0; gnt_en = 1'b1; resp_en = 1'b1; lat = 1;
      step(); step();
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) step();
      branch_to(32'h400);
      n_chk++;
      if (!(s_rv && s_ov)) begin
         n_fail++; $display("FAIL flush_setup: got rvalid=%b out_valid=%b, required 1 1", s_rv, s_ov);
      end
      step();
      n_chk++;
      if (out_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL flush_empty: got out_valid=%b, required 0", out_valid_o);
      end
      wait_pop("flush_first", 32'h400);
      drain();
   endtask

   task automatic test_bypass_latency();
      do_reset();
      rdy = 1'b1; gnt_en = 1'b1; resp_en = 1'b1; lat = 1;
      for (int i = 0; i < 10 && first_ov < 0; i++) step();
      n_chk++;
      if (first_rv < 0 || first_ov < 0 || first_ov - first_rv != EXP_LAT || first_instr !== 32'h13) begin
         n_fail++;
         $display("FAIL rvalid_latency: got lat=%0d instr=%h, required lat=%0d instr=00000013",
                  first_ov - first_rv, first_instr, EXP_LAT);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 400; i++) begin
         rdy     = ($urandom_range(0, 3) != 0);
         gnt_en  = ($urandom_range(0, 2) != 0);
         resp_en = ($urandom_range(0, 3) != 0);
         lat     = $urandom_range(1, 3);
         if ($urandom_range(0, 15) == 0) branch_to($urandom() & 32'h0000_0fff);
         else step();
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_branch_discard();
      test_retarget();
      test_branch_rvalid_pop();
      test_bypass_latency();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
